// File: rtl/mips_mem_pkg.sv
// Shared MIPS32 data-memory definitions: size codes, LSU FSM states, byte enables
// and the store lane-placement helpers used by dmem_lsu.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DATA   = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic [3:0] WEA_NONE = 4'b0000;
    localparam logic [3:0] WEA_ALL  = 4'b1111;

    // Reserved size code 3 behaves as a word everywhere.
    function automatic logic [3:0] store_wea(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] wea;
        case (size)
            SZ_BYTE: wea = 4'b0001 << off;
            SZ_HALF: wea = off[1] ? 4'b1100 : 4'b0011;
            default: wea = WEA_ALL;
        endcase
        return wea;
    endfunction

    function automatic logic [31:0] store_dina(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] dina;
        case (size)
            SZ_BYTE: dina = {4{wdata[7:0]}};
            SZ_HALF: dina = {2{wdata[15:0]}};
            default: dina = wdata;
        endcase
        return dina;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            default: bad = (off != 2'd0);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response handshake bundle between the MEM stage (master) and dmem_lsu (slave).
interface dmem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_lane_extract.sv
// Combinational little-endian lane select and sign/zero extension of a RAM read word.
module dmem_lane_extract
    import mips_mem_pkg::*;
(
    input  logic [31:0] douta,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sgn,
    output logic [31:0] result
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = douta[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lane[off];
    assign half_sel = off[1] ? douta[31:16] : douta[15:0];

    always_comb begin
        result = douta;
        case (size)
            SZ_BYTE: result = {{24{sgn & byte_sel[7]}}, byte_sel};
            SZ_HALF: result = {{16{sgn & half_sel[15]}}, half_sel};
            default: result = douta;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// MIPS32 load/store unit driving a synchronous byte-writable RAM with 1-cycle read latency.
// Optional misaligned-access trap: define DMEM_LSU_MISALIGN_EXC_EN.
module dmem_lsu
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_lsu_if.slave         bus,
    output logic              ram_ena,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_wea,
    output logic [31:0]       ram_dina,
    input  logic [31:0]       ram_douta
);

    logic [1:0]        state_reg;
    logic              req_ready_reg;
    logic              resp_valid_reg;
    logic [31:0]       resp_rdata_reg;
    logic              ram_ena_reg;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic [3:0]        ram_wea_reg;
    logic [31:0]       ram_dina_reg;
    logic              we_reg;
    logic [1:0]        off_reg;
    logic [1:0]        size_reg;
    logic              signed_reg;
    logic [31:0]       load_data;
    logic              misaligned;
    logic              unused_addr_hi;

    // Bits above the RAM window are dropped without a range check.
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

`ifdef DMEM_LSU_MISALIGN_EXC_EN
    assign misaligned = is_misaligned(bus.req_size, bus.req_addr[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    dmem_lane_extract u_extract (
        .douta  (ram_douta),
        .off    (off_reg),
        .size   (size_reg),
        .sgn    (signed_reg),
        .result (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= 32'd0;
            ram_ena_reg    <= 1'b0;
            ram_addr_reg   <= '0;
            ram_wea_reg    <= WEA_NONE;
            ram_dina_reg   <= 32'd0;
            we_reg         <= 1'b0;
            off_reg        <= 2'd0;
            size_reg       <= SZ_BYTE;
            signed_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_ready_reg <= 1'b0;
                        we_reg        <= bus.req_we;
                        off_reg       <= bus.req_addr[1:0];
                        size_reg      <= bus.req_size;
                        signed_reg    <= bus.req_signed;
                        if (misaligned) begin
                            // Trap without touching the RAM.
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_rdata_reg <= 32'd0;
                        end else begin
                            state_reg    <= ACCESS;
                            ram_ena_reg  <= 1'b1;
                            ram_addr_reg <= bus.req_addr[ADDR_W+1:2];
                            ram_wea_reg  <= bus.req_we ? store_wea(bus.req_size, bus.req_addr[1:0])
                                                       : WEA_NONE;
                            ram_dina_reg <= store_dina(bus.req_size, bus.req_wdata);
                        end
                    end
                end
                ACCESS: begin
                    ram_ena_reg <= 1'b0;
                    ram_wea_reg <= WEA_NONE;
                    if (we_reg) begin
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                        resp_rdata_reg <= 32'd0;
                    end else begin
                        state_reg <= DATA;
                    end
                end
                DATA: begin
                    state_reg      <= RESP;
                    resp_valid_reg <= 1'b1;
                    resp_rdata_reg <= load_data;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state_reg      <= IDLE;
                        resp_valid_reg <= 1'b0;
                        req_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                end
            endcase
        end
    end

`ifdef DMEM_LSU_MISALIGN_EXC_EN
    logic resp_err_reg;

    // Held through RESP; refreshed only when the next request is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_err_reg <= 1'b0;
        end else if (state_reg == IDLE && bus.req_valid) begin
            resp_err_reg <= misaligned;
        end
    end

    assign bus.resp_err = resp_err_reg;
`else
    assign bus.resp_err = 1'b0;
`endif

    assign bus.req_ready  = req_ready_reg;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_rdata = resp_rdata_reg;
    assign ram_ena        = ram_ena_reg;
    assign ram_addr       = ram_addr_reg;
    assign ram_wea        = ram_wea_reg;
    assign ram_dina       = ram_dina_reg;

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store initiator between the MIPS32 MEM stage and the synchronous byte-writable data RAM.
- Accepts one byte/half/word load or store per transaction over a valid/ready handshake.
- Drives RAM ena/addr/wea/dina, absorbs the RAM's 1-cycle read latency, and returns the lane-extracted, sign/zero-extended load result.
- Byte order is little-endian: byte offset 0 maps to bits 7:0.

Parameters:
ADDR_W, 17, RAM word-address width; ram_addr = req_addr[ADDR_W+1:2]

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request valid
req_ready  output  1  block can accept a request (high only in IDLE)
req_we  input  1  1=store, 0=load
req_size  input  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
req_signed  input  1  loads only: 1=sign-extend (LB/LH), 0=zero-extend (LBU/LHU)
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  response valid
resp_ready  input  1  consumer accepts response
resp_rdata  output  32  extended load data; 0 for stores
resp_err  output  1  misaligned access flag (only with macro)
ram_ena  output  1  RAM enable
ram_addr  output  ADDR_W  RAM word address
ram_wea  output  4  RAM byte write enables
ram_dina  output  32  RAM write data
ram_douta  input  32  RAM read data, valid the cycle after an enabled read edge

Behaviour:
- All outputs registered.
- Async reset values: state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; ram_ena=0; ram_addr=0; ram_wea=0; ram_dina=0.
- FSM states: IDLE, ACCESS, DATA, RESP.
- IDLE: on req_valid, capture request. Register ram_addr, ram_wea (stores only, else 0), ram_dina, ram_ena=1 and the offset/size/signed fields, then go to ACCESS.
- ACCESS: RAM acts at the closing edge.
  - Store: ram_ena=0, ram_wea=0, go to RESP with resp_rdata=0.
  - Load: ram_ena=0, go to DATA.
- DATA: sample ram_douta; extract lane by offset; extend; register into resp_rdata; go to RESP.
  - Deasserted ena in DATA does not corrupt the sample, which is taken at the same edge.
- RESP: resp_valid=1; hold resp_rdata/resp_err stable until resp_valid&&resp_ready, then return to IDLE with resp_valid=0.
- Latency (accept edge to first resp_valid cycle): store 2 cycles, load 3 cycles. Throughput is one transaction per 3 (store) or 4 (load) cycles, with no overlap.
- Store lane mapping, off=req_addr[1:0]:
  - Byte: wea = 4'b0001<<off; dina = {4{wdata[7:0]}}.
  - Half: wea = off[1] ? 4'b1100 : 4'b0011; dina = {2{wdata[15:0]}}.
  - Word: wea = 4'b1111; dina = wdata.
- Load extraction:
  - Byte: douta[8*off+7 -: 8], extended per signed.
  - Half: off[1] ? douta[31:16] : douta[15:0], extended per signed.
  - Word: douta unchanged; req_signed ignored.
- Without the macro, misalignment is silently ignored: half uses off[1] only, word ignores off; resp_err stays 0.
- req_valid while not IDLE is ignored (req_ready=0); the requester must hold the request.
- Reset mid-transaction aborts immediately. A store whose ACCESS edge coincides with reset assertion is not guaranteed.
- Address bits above ADDR_W+1 are discarded; no range check.

Optional Feature:
DMEM_LSU_MISALIGN_EXC_EN
- Defined: half with off[0]=1, or word with off!=0, is misaligned. IDLE goes directly to RESP with resp_err=1 and resp_rdata=0; ram_ena/ram_wea stay 0, so no RAM access occurs. Latency is 1 cycle.
- Undefined: resp_err is tied 0 and no detection logic exists.

Decomposition:
- Shared package mips_mem_pkg:
  - Size encodings: SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2.
  - FSM state constants: IDLE/ACCESS/DATA/RESP.
  - Byte-enable constants: WEA_NONE, WEA_ALL.
- One natural sub-module, dmem_lane_extract: combinational douta+offset+size+signed -> 32-bit result. Reused by the bench model.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> wea=1111 at word 4; load resp_rdata=0xDEADBEEF three cycles after accept.
- SB addr 0x13 data 0x000000A5 onto word 0x11223344, then LB 0x13 -> wea=1000, dina=0xA5A5A5A5; memory 0xA5223344; LB=0xFFFFFFA5, LBU=0x000000A5.
- SH addr 0x22 data 0x00008001, then LH 0x22 / LHU 0x22 -> wea=1100; LH=0xFFFF8001, LHU=0x00008001.
- Load with resp_ready held low 5 cycles -> resp_valid and resp_rdata stable 5+ cycles; req_ready=0 throughout; second req_valid ignored.
- rst_n pulsed low during DATA of a load -> all outputs return to reset values asynchronously; next LW completes normally.
- With DMEM_LSU_MISALIGN_EXC_EN: LW addr 0x21 -> resp_err=1 one cycle after accept, ram_ena never asserted. Without the macro: resp_err=0 and the word at 0x20 is returned.
